// File: rtl/battleship_pkg.sv
// Shared types and constants for the Battleship controller and VGA renderer.
package battleship_pkg;

  localparam int unsigned BOARD_N = 5;
  localparam int unsigned CUR_W   = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIP  = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    PLACE = 2'd0,
    PLAY  = 2'd1,
    WIN   = 2'd2,
    LOSE  = 2'd3
  } phase_t;

  typedef cell_t [BOARD_N-1:0][BOARD_N-1:0] board_t;

  function automatic logic [CUR_W-1:0] wrap_inc(input logic [CUR_W-1:0] v);
    return (v == CUR_W'(BOARD_N - 1)) ? '0 : v + CUR_W'(1);
  endfunction

  function automatic logic [CUR_W-1:0] wrap_dec(input logic [CUR_W-1:0] v);
    return (v == '0) ? CUR_W'(BOARD_N - 1) : v - CUR_W'(1);
  endfunction

endpackage

// File: rtl/battleship_game_ctrl_if.sv
// Button inputs and board/status outputs of the Battleship game controller.
interface battleship_game_ctrl_if;
  import battleship_pkg::*;

  logic               btn_up;
  logic               btn_down;
  logic               btn_left;
  logic               btn_right;
  logic               btn_fire;
  board_t             board;
  logic [CUR_W-1:0]   cursor_row;
  logic [CUR_W-1:0]   cursor_col;
  phase_t             phase;
  logic [4:0]         placed;
  logic [7:0]         shots_left;
  logic [4:0]         hits;
  logic               shot_strobe;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_fire,
    input  board, cursor_row, cursor_col, phase, placed, shots_left, hits, shot_strobe
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_fire,
    output board, cursor_row, cursor_col, phase, placed, shots_left, hits, shot_strobe
  );

endinterface

// File: rtl/battleship_game_ctrl_turn_timer.sv
// Idle-turn timer: counts enabled cycles and pulses expire on the last one.
module turn_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] count_q;

  assign expire_o = enable_i && (count_q == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (!enable_i || clear_i || expire_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/battleship_game_ctrl.sv
// Battleship game controller: board state, cursor, shot/hit counters and phase FSM.
module battleship_game_ctrl
  import battleship_pkg::*;
#(
  parameter int unsigned SHIP_CELLS     = 5,
  parameter int unsigned MAX_SHOTS      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input logic                   clk,
  input logic                   reset,
  battleship_game_ctrl_if.slave bus
);

  board_t           board_q;
  logic [CUR_W-1:0] row_q, col_q;
  logic [CUR_W-1:0] row_mv, col_mv;
  phase_t           phase_q;
  logic [4:0]       placed_q, hits_q, hits_nx;
  logic [7:0]       shots_q, shots_nx;
  logic             strobe_q;
  cell_t            cur_cell;
  logic             moved, shot, expire, in_play;

  always_comb begin
    cur_cell = board_q[row_q][col_q];
    in_play  = (phase_q == PLAY);
    row_mv   = row_q;
    col_mv   = col_q;
    if (bus.btn_up)         row_mv = wrap_dec(row_q);
    else if (bus.btn_down)  row_mv = wrap_inc(row_q);
    else if (bus.btn_left)  col_mv = wrap_dec(col_q);
    else if (bus.btn_right) col_mv = wrap_inc(col_q);
    // Fire owns the cycle: direction pulses arriving with it are dropped.
    moved    = (phase_q == PLACE || phase_q == PLAY) && !bus.btn_fire &&
               (bus.btn_up || bus.btn_down || bus.btn_left || bus.btn_right);
    shot     = in_play && bus.btn_fire && (cur_cell == EMPTY || cur_cell == SHIP);
    hits_nx  = hits_q + ((cur_cell == SHIP) ? 5'd1 : 5'd0);
    shots_nx = shots_q - 8'd1;
  end

  turn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_turn_timer (
    .clk      (clk),
    .rst_n    (reset),
    .enable_i (in_play),
    .clear_i  (shot || moved),
    .expire_o (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      board_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      phase_q  <= PLACE;
      placed_q <= '0;
      shots_q  <= 8'(MAX_SHOTS);
      hits_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (moved) begin
        row_q <= row_mv;
        col_q <= col_mv;
      end
      unique case (phase_q)
        PLACE: begin
          if (bus.btn_fire) begin
            if (cur_cell == EMPTY) begin
              board_q[row_q][col_q] <= SHIP;
              placed_q <= placed_q + 5'd1;
              if (placed_q + 5'd1 == 5'(SHIP_CELLS)) begin
                phase_q <= PLAY;
                shots_q <= 8'(MAX_SHOTS);
                hits_q  <= '0;
              end
            end else begin
              board_q[row_q][col_q] <= EMPTY;
              placed_q <= placed_q - 5'd1;
            end
          end
        end
        PLAY: begin
          // A consumed fire masks a simultaneous timeout; an ignored fire does not.
          if (shot) begin
            board_q[row_q][col_q] <= (cur_cell == SHIP) ? HIT : MISS;
            hits_q   <= hits_nx;
            shots_q  <= shots_nx;
            strobe_q <= 1'b1;
            if (hits_nx == 5'(SHIP_CELLS)) phase_q <= WIN;
            else if (shots_nx == '0)       phase_q <= LOSE;
          end else if (expire) begin
            shots_q  <= shots_nx;
            strobe_q <= 1'b1;
            if (shots_nx == '0) phase_q <= LOSE;
          end
        end
        WIN, LOSE: begin
          if (bus.btn_fire) begin
            board_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            phase_q  <= PLACE;
            placed_q <= '0;
            shots_q  <= 8'(MAX_SHOTS);
            hits_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.board       = board_q;
  assign bus.cursor_row  = row_q;
  assign bus.cursor_col  = col_q;
  assign bus.phase       = phase_q;
  assign bus.placed      = placed_q;
  assign bus.shots_left  = shots_q;
  assign bus.hits        = hits_q;
  assign bus.shot_strobe = strobe_q;

endmodule

// File: doc/battleship_game_ctrl.md
# battleship_game_ctrl

Game controller for the 5x5 Battleship board drawn by the VGA display path. It holds the board cell states, the player cursor, the shot and hit counters and the game phase, and sequences placement → play → end-of-game from single-cycle button pulses. Its board and cursor outputs drive the VGA renderer directly, and its status outputs drive the LEDs and seven-segment displays.

## Interface
- SHIP_CELLS, 5: ship cells placed before play starts (1..25)
- MAX_SHOTS, 12: shots available per game (1..255)
- TIMEOUT_CYCLES, 500_000_000: idle cycles in PLAY before a shot is forfeited (10 s at 50 MHz)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_up / btn_down / btn_left / btn_right / btn_fire  in  1 each  synchronised, debounced, one-cycle pulses
- board  out  [4:0][4:0] cell_t  state of each cell, indexed [row][col]
- cursor_row, cursor_col  out  3 each  cursor position, 0..4
- phase  out  phase_t  PLACE / PLAY / WIN / LOSE
- placed  out  5  ship cells currently placed
- shots_left  out  8  remaining shots
- hits  out  5  ship cells hit
- shot_strobe  out  1  one-cycle pulse, registered, when a shot is resolved (fire or timeout)

## Operation
- cell_t values: EMPTY=0, SHIP=1, HIT=2, MISS=3.
- Reset values:
  - every board cell EMPTY
  - cursor (0,0)
  - phase=PLACE
  - placed=0, shots_left=MAX_SHOTS, hits=0
  - shot_strobe=0
  - timer cleared
- Cursor movement:
  - Active in PLACE and PLAY only; frozen in WIN/LOSE.
  - Moves wrap around: row 4 + down → 0; col 0 + left → 4.
  - One move per cycle, priority up > down > left > right.
  - btn_fire in the same cycle takes priority: all direction pulses that cycle are ignored.
- PLACE phase (fire at the cursor cell):
  - EMPTY → SHIP, placed+1.
  - SHIP → EMPTY, placed−1.
  - When a fire makes placed == SHIP_CELLS, phase → PLAY on that same edge, with shots_left=MAX_SHOTS, hits=0 and the timer cleared.
- PLAY phase (fire at the cursor cell):
  - SHIP → HIT, hits+1, shots_left−1, shot_strobe.
  - EMPTY → MISS, shots_left−1, shot_strobe.
  - HIT or MISS → ignored: no shot consumed, no strobe, timer not cleared.
- Turn timer:
  - Counts every PLAY cycle.
  - Cleared by any consumed shot or any cursor move.
  - On reaching TIMEOUT_CYCLES−1: shots_left−1, shot_strobe, timer cleared, board unchanged.
  - If a fire and the timeout land in the same cycle, only the fire is counted.
- End of game:
  - After a resolved shot, hits == SHIP_CELLS → WIN.
  - Otherwise, shots_left reaching 0 → LOSE.
  - A hit on the final shot yields WIN, not LOSE.
- WIN/LOSE phase:
  - Outputs hold.
  - btn_fire → full clear (same values as reset) on that edge, phase=PLACE.
- Reset asserted at any point returns every output to its reset value asynchronously.

## Timing
- All outputs are registered.
- Every input pulse takes effect at the next rising edge; new values are visible one cycle after the pulse.
- A phase change takes effect on the same edge as the triggering update: board, counters and phase change together, so there are no intermediate cycles.
- shot_strobe is high for exactly one cycle per resolved shot.
- The timer is wide enough for TIMEOUT_CYCLES ($clog2) and does not run outside PLAY.

## Structure
- battleship_pkg (shared with the VGA renderer) holds:
  - cell_t and phase_t enums
  - BOARD_N=5
  - cursor width constant
- turn_timer is a separate sub-module:
  - Ports: clear and enable in; expire pulse out.
  - Parameter: TIMEOUT_CYCLES.
- The phase FSM, board register array and counters stay in battleship_game_ctrl.

## Test plan
- Reset, then btn_up once → cursor (4,0); btn_left once → (4,4); fire+right in the same cycle → cursor unchanged, cell (4,4)=SHIP, placed=1.
- Fire on (4,4) again → cell EMPTY, placed=0. Place 5 ships at (0,0)..(0,4) → phase=PLAY on the 5th fire edge, shots_left=12.
- In PLAY: fire on (0,0) → HIT, hits=1, shots_left=11, one shot_strobe. Fire on (0,0) again → no change, no strobe. Fire on (1,0) → MISS, shots_left=10.
- TIMEOUT_CYCLES=20 with no input → shots_left decrements at cycle 20 with a strobe, then again at cycle 40. A cursor move at cycle 15 delays the first timeout to cycle 35.
- MAX_SHOTS=5: hit all 5 ships in 5 shots → WIN, shots_left=0. Separate game with 5 misses → LOSE. Fire in WIN/LOSE → all cells EMPTY, phase=PLACE.
- Assert reset mid-PLAY → all outputs return to reset values immediately, without waiting for a clock edge.
